// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; latency 1, or WIDTH+1 for shift-add MUL when ALU_MUL_EN is defined (else 101 is reserved).
// Backpressure: the result is held while out_valid && !out_ready; in_ready is low in BUSY and in HOLD without out_ready.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             err
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cy_q, cy_d;
    logic             z_q, z_d;
    logic             ov_q, ov_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_mul;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] op_res;
    logic             op_cy;
    logic             op_ov;
    logic             op_err;

    assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath straight off the inputs; results are captured only on acceptance.
    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        diff_w = {1'b0, a} - {1'b0, b};
        op_res = '0;
        op_cy  = 1'b0;
        op_ov  = 1'b0;
        op_err = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                op_res = sum_w[WIDTH-1:0];
                op_cy  = sum_w[WIDTH];
                op_ov  = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_SUB: begin
                op_res = diff_w[WIDTH-1:0];
                op_cy  = diff_w[WIDTH];
                op_ov  = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
            end
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_ANDN: op_res = a & ~b;
            OP_XOR:  op_res = a ^ b;
            // 111 always; 101 too unless the multiplier steers it to BUSY.
            default: op_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_last;

    assign is_mul    = (alu_sel == OP_MUL);
    assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign mul_last  = (cnt_q == CW'(WIDTH - 1));

    // One multiplier bit per BUSY cycle; the last step feeds the result registers directly.
    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (accept && is_mul) begin
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
        end else if (state_q == BUSY) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cy_d    = cy_q;
        z_d     = z_q;
        ov_d    = ov_q;
        err_d   = err_q;
        case (state_q)
            IDLE, HOLD: begin
                if ((state_q == HOLD) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    if (is_mul) begin
                        state_d = BUSY;
                    end else begin
                        state_d = HOLD;
                        res_d   = op_res;
                        cy_d    = op_cy;
                        z_d     = (op_res == '0);
                        ov_d    = op_ov;
                        err_d   = op_err;
                    end
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) begin
                    state_d = HOLD;
                    res_d   = prod_step[WIDTH-1:0];
                    cy_d    = |prod_step[2*WIDTH-1:WIDTH];
                    z_d     = (prod_step[WIDTH-1:0] == '0);
                    ov_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            cy_q    <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign result    = res_q;
    assign carry_out = cy_q;
    assign zero      = z_q;
    assign overflow  = ov_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vector table, hand-written corner sequences, random stream vs arithmetic model.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   alu_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out, zero, overflow, err;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .zero(zero), .overflow(overflow), .err(err)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         cy;
        logic         z;
        logic         ov;
        logic         er;
    } exp_t;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   vs;
        exp_t         e;
        int           lat;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t dut_out();
        return {result, carry_out, zero, overflow, err};
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] op);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint ua = longint'(xa);
        longint ub = longint'(xb);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sbv = (ub >= m / 2) ? ub - m : ub;
        longint r = 0;
        longint s;
        e = '0;
        case (op)
            3'd0: begin r = ua + ub; e.cy = (r >= m); s = sa + sbv; e.ov = (s >= m / 2) || (s < -(m / 2)); end
            3'd1: begin r = ua - ub; e.cy = (ua < ub); s = sa - sbv; e.ov = (s >= m / 2) || (s < -(m / 2)); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua & ~ub & (m - 1);
            3'd6: r = ua ^ ub;
`ifdef ALU_MUL_EN
            3'd5: begin r = ua * ub; e.cy = (r >= m); end
`endif
            default: begin r = 0; e.er = 1'b1; end
        endcase
        r = ((r % m) + m) % m;
        e.res = W'(r);
        e.z = (r == 0);
        return e;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] op,
                                input logic [W-1:0] r, input logic c, input logic zz, input logic o,
                                input logic e, input int l);
        vec_t v;
        v.va = xa; v.vb = xb; v.vs = op;
        v.e = {r, c, zz, o, e};
        v.lat = l;
        return v;
    endfunction

    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] op, input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = xa; b = xb; alu_sel = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); alu_sel = 3'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        out_ready = 1'b0;
        issue(v.va, v.vb, v.vs, tag);
        n = 1;
        while (!out_valid && n < 40) begin
            check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(v.lat));
        check({tag, "_result_flags"}, 32'(dut_out()), 32'(v.e));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_retire"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   seen;
        logic [2:0] rop;

        tbl.push_back(mk(8'd200, 8'd100, 3'd0, 8'd44,  1'b1, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'd100, 8'd100, 3'd0, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(8'd5,   8'd5,   3'd1, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'd4,   8'd9,   3'd1, 8'd251, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'hCC,  8'hAA,  3'd4, 8'h44,  1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'hF0,  8'h3C,  3'd2, 8'h30,  1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'hF0,  8'h0F,  3'd3, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'h5A,  8'h5A,  3'd6, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(8'h80,  8'h01,  3'd1, 8'h7F,  1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(8'h7F,  8'h01,  3'd0, 8'h80,  1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(8'd5,   8'd3,   3'd7, 8'h00,  1'b0, 1'b1, 1'b0, 1'b1, 1));
`ifdef ALU_MUL_EN
        tbl.push_back(mk(8'd15,  8'd17,  3'd5, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 9));
        tbl.push_back(mk(8'd16,  8'd16,  3'd5, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0, 9));
        tbl.push_back(mk(8'hFF,  8'hFF,  3'd5, 8'h01,  1'b1, 1'b0, 1'b0, 1'b0, 9));
`else
        tbl.push_back(mk(8'd15,  8'd17,  3'd5, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 1));
`endif

        // Reset state
        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result_flags", 32'(dut_out()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: ADD result held for 5 cycles, then retired alongside a new XOR
        out_ready = 1'b0;
        issue(8'd200, 8'd100, 3'd0, "bp_add");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_result_flags", i), 32'(dut_out()), 32'(exp_t'({8'd44, 1'b1, 1'b0, 1'b0, 1'b0})));
            check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'hFF; alu_sel = 3'd6;
        #1;
        check("bp_xor_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_xor_out_valid", 32'(out_valid), 32'd1);
        check("bp_xor_result_flags", 32'(dut_out()), 32'(exp_t'({8'hF0, 1'b0, 1'b0, 1'b0, 1'b0})));
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset three cycles into an operation (a multiply when it exists)
        out_ready = 1'b0;
`ifdef ALU_MUL_EN
        rop = 3'd5;
`else
        rop = 3'd0;
`endif
        issue(8'd15, 8'd17, rop, "rst_mid");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result_flags", 32'(dut_out()), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_stale_result", 32'(seen), 32'd0);

        // Random stream against the model with random backpressure
        sb.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            a = W'($urandom); b = W'($urandom); alu_sel = 3'($urandom_range(0, 7));
            #1;
            check("rnd_in_ready", 32'(in_ready), 32'((sb.size() == 0) || (out_valid && out_ready)));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("rnd_result_flags", 32'(dut_out()), 32'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, alu_sel));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            if (out_valid) begin
                check("drain_result_flags", 32'(dut_out()), 32'(sb[0]));
                void'(sb.pop_front());
            end
            @(posedge clk); #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operation request present.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH each, unsigned/two's-complement operands.
REQ-007 SHALL have port alu_sel, input, 3, opcode.
REQ-008 SHALL have port out_valid, output, 1, result held on outputs.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-010 SHALL have port result, output, WIDTH, operation result.
REQ-011 SHALL have ports carry_out, zero, overflow and err, output, 1 each, status flags qualified by out_valid.

Function
REQ-012 SHALL decode alu_sel: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 ANDN a&~b; 101 MUL; 110 XOR; 111 reserved.
REQ-013 SHALL implement FSM states IDLE (no result), BUSY (multiply iterating) and HOLD (result valid); reset state is IDLE.
REQ-014 SHALL drive in_ready = (state==IDLE) or (state==HOLD and out_ready); in_ready is 0 in BUSY.
REQ-015 SHALL accept a request on any edge with in_valid and in_ready, capturing a, b and alu_sel.
REQ-016 SHALL, for non-MUL opcodes, enter HOLD with out_valid=1 on the cycle after acceptance (latency 1), giving throughput of 1 op/cycle under continuous out_ready.
REQ-017 SHALL, for MUL, enter BUSY, perform WIDTH shift-add iterations (one per cycle), then enter HOLD (out_valid asserts WIDTH+1 cycles after acceptance).
REQ-018 SHALL set MUL result to the low WIDTH bits of the 2*WIDTH product, and carry_out=1 iff the high WIDTH bits are nonzero.
REQ-019 SHALL set ADD carry_out to the carry out of the MSB, and SUB carry_out to 1 iff a<b unsigned (borrow).
REQ-020 SHALL set overflow to signed two's-complement overflow for ADD/SUB, and to 0 for all other opcodes.
REQ-021 SHALL set carry_out to 0 for AND, OR, ANDN and XOR.
REQ-022 SHALL set zero = (result==0) for every opcode, including reserved.
REQ-023 SHALL, for opcode 111, return result=0, carry_out=0, overflow=0, err=1 at latency 1; err SHALL be 0 for every legal opcode.
REQ-024 SHALL hold result and all flags stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in HOLD with out_ready=1 and no new request, return to IDLE and deassert out_valid next cycle.
REQ-026 SHALL, in HOLD with out_ready=1 and a new request accepted in the same cycle, retire the old result and load the new operation in that cycle (no bubble for latency-1 ops).
REQ-027 SHALL ignore in_valid while BUSY; the operands captured at acceptance SHALL be unaffected by input changes.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, carry_out=0, zero=0, overflow=0 and err=0.
REQ-029 SHALL drive in_ready=1 after reset release.
REQ-030 SHALL abandon any in-flight multiply on reset, with no result produced afterwards.

Configuration
REQ-031 SHALL compile the multi-cycle multiplier and the BUSY state only when macro ALU_MUL_EN is defined.
REQ-032 SHALL, without ALU_MUL_EN, treat opcode 101 exactly as reserved: result=0, zero=1, err=1 at latency 1, with BUSY unreachable.

Verification (WIDTH=8)
REQ-033 SHALL cover ADD 200+100 -> result 44, carry_out 1, overflow 0; ADD 100+100 -> result 200, carry_out 0, overflow 1; each with out_valid one cycle after acceptance.
REQ-034 SHALL cover SUB 5-5 -> result 0, zero 1, carry_out 0; SUB 4-9 -> result 251, carry_out 1; ANDN 0xCC,0xAA -> 0x44.
REQ-035 SHALL cover, with ALU_MUL_EN defined, MUL 15*17 -> result 255, carry_out 0, out_valid 9 cycles after acceptance, in_ready 0 throughout; MUL 16*16 -> result 0, carry_out 1, zero 1.
REQ-036 SHALL cover back-pressure: out_ready held 0 for 5 cycles after an ADD result -> result and flags unchanged, in_ready 0; on out_ready=1 with a new XOR request -> the XOR result appears the next cycle.
REQ-037 SHALL cover opcode 111 -> err 1, result 0; and, without ALU_MUL_EN, opcode 101 -> err 1.
REQ-038 SHALL cover rst_n asserted 3 cycles into a MUL -> out_valid 0 immediately, in_ready 1 after release, no stale result appears.
